// File: rtl/usb_dev_rx.sv
// Device-side USB serial receiver: SYNC hunt, NRZI/bit-unstuff decode, EOP detect,
// LSB-first packet assembly with PID and CRC5/CRC16 residual checks.
module usb_dev_rx #(
  parameter int PKT_W     = 99,
  parameter int STUFF_RUN = 6
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             rx_en,
  input  logic             dp,
  input  logic             dm,
  output logic [PKT_W-1:0] pkt_out,
  output logic [6:0]       pkt_len,
  output logic             pkt_valid,
  output logic             crc_ok,
  output logic             rx_err,
  output logic             rx_busy
);

  localparam int OW = $clog2(STUFF_RUN + 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    ERR
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           prev_lvl;
  logic [OW-1:0]  ones_cnt;
  logic [2:0]     sub_cnt;
  logic [4:0]     crc5;
  logic [15:0]    crc16;

  logic is_j, is_k, is_se0, is_se1;
  logic nrzi_bit, stuff_slot;
  logic start_pkt, store_bit, drop_bit, pkt_done, err_entry;
  logic check_ok, type_ok;
  logic [7:0] pid;

  assign is_j       = dp & ~dm;
  assign is_k       = ~dp & dm;
  assign is_se0     = ~dp & ~dm;
  assign is_se1     = dp & dm;
  assign nrzi_bit   = (dp == prev_lvl);
  assign stuff_slot = (ones_cnt == OW'(STUFF_RUN));
  assign pid        = pkt_out[7:0];

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    start_pkt = 1'b0;
    store_bit = 1'b0;
    drop_bit  = 1'b0;
    pkt_done  = 1'b0;
    if (!rx_en) begin
      state_nxt = IDLE;
    end else if (is_se1 && state != IDLE) begin
      state_nxt = ERR;
    end else begin
      case (state)
        IDLE: if (is_k) begin
          state_nxt = SYNC;
          start_pkt = 1'b1;
        end
        // Seven cycles after the first K must decode to 0,0,0,0,0,0,1.
        SYNC: begin
          if (!(is_j || is_k) || (nrzi_bit != (sub_cnt == 3'd6))) state_nxt = ERR;
          else if (sub_cnt == 3'd6)                              state_nxt = DATA;
        end
        DATA: begin
          if (is_se0) begin
            state_nxt = EOP;
          end else if (stuff_slot) begin
            if (nrzi_bit) state_nxt = ERR;
            else          drop_bit  = 1'b1;
          end else if (pkt_len == 7'(PKT_W)) begin
            state_nxt = ERR;
          end else begin
            store_bit = 1'b1;
          end
        end
        EOP: begin
          if (sub_cnt == 3'd0) begin
            if (!is_se0) state_nxt = ERR;
          end else if (is_j) begin
            state_nxt = IDLE;
            pkt_done  = 1'b1;
          end else begin
            state_nxt = ERR;
          end
        end
        ERR:     if (is_j && sub_cnt == 3'd1) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_busy   = (state != IDLE);
    err_entry = (state_nxt == ERR) && (state != ERR);
  end

  always_comb begin
    type_ok = 1'b0;
    case (pid[3:0])
      4'b0001, 4'b1001, 4'b1101: type_ok = (pkt_len == 7'd24) && (crc5 == 5'b01100);
      4'b0011, 4'b1011:          type_ok = (pkt_len >= 7'd24) && (pkt_len[2:0] == 3'd0) &&
                                           (crc16 == 16'h800D);
      4'b0010, 4'b1010, 4'b1110: type_ok = (pkt_len == 7'd8);
      default:                   type_ok = 1'b0;
    endcase
    check_ok = (pkt_len >= 7'd8) && (pid[7:4] == ~pid[3:0]) && type_ok;
  end

  // sub_cnt is the SYNC bit position, the EOP step, or the consecutive-J count in ERR.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      sub_cnt <= '0;
    end else if (state_nxt != state) begin
      sub_cnt <= '0;
    end else if (state == ERR) begin
      sub_cnt <= is_j ? 3'd1 : 3'd0;
    end else if (state == SYNC || state == EOP) begin
      sub_cnt <= sub_cnt + 3'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      prev_lvl  <= 1'b1;
      ones_cnt  <= '0;
      crc5      <= 5'b11111;
      crc16     <= 16'hFFFF;
      pkt_out   <= '0;
      pkt_len   <= '0;
      pkt_valid <= 1'b0;
      crc_ok    <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      pkt_valid <= pkt_done;
      crc_ok    <= pkt_done & check_ok;
      rx_err    <= err_entry;
      if (start_pkt || state == SYNC || state == DATA) prev_lvl <= dp;
      if (start_pkt) begin
        ones_cnt <= '0;
        crc5     <= 5'b11111;
        crc16    <= 16'hFFFF;
        pkt_out  <= '0;
        pkt_len  <= '0;
      end else begin
        if (store_bit || drop_bit) ones_cnt <= nrzi_bit ? ones_cnt + 1'b1 : '0;
        if (store_bit) begin
          pkt_out <= pkt_out | (PKT_W'(nrzi_bit) << pkt_len);
          pkt_len <= pkt_len + 7'd1;
          // The PID byte is excluded from both CRCs.
          if (pkt_len >= 7'd8) begin
            crc5  <= {crc5[3:0], 1'b0} ^ ({5{nrzi_bit ^ crc5[4]}} & 5'b00101);
            crc16 <= {crc16[14:0], 1'b0} ^ ({16{nrzi_bit ^ crc16[15]}} & 16'h8005);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_dev_rx.sv
// Directed bench for usb_dev_rx: encodes packets onto dp/dm (NRZI + stuffing) and
// checks strobes, captured packet contents and error handling.
module tb_usb_dev_rx;

  localparam int PKT_W = 99;

  logic             clk;
  logic             rst_b;
  logic             rx_en;
  logic             dp;
  logic             dm;
  logic [PKT_W-1:0] pkt_out;
  logic [6:0]       pkt_len;
  logic             pkt_valid;
  logic             crc_ok;
  logic             rx_err;
  logic             rx_busy;

  usb_dev_rx #(.PKT_W(PKT_W), .STUFF_RUN(6)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .rx_en     (rx_en),
    .dp        (dp),
    .dm        (dm),
    .pkt_out   (pkt_out),
    .pkt_len   (pkt_len),
    .pkt_valid (pkt_valid),
    .crc_ok    (crc_ok),
    .rx_err    (rx_err),
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [PKT_W-1:0] cap_out;
  logic [6:0]       cap_len;
  logic             cap_ok;
  logic             lvl;
  int               ones;

  always @(negedge clk) begin
    if (pkt_valid) begin
      valid_cnt++;
      cap_out = pkt_out;
      cap_len = pkt_len;
      cap_ok  = crc_ok;
    end
    if (rx_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_lvl(input logic l);
    dp = l;
    dm = ~l;
    @(negedge clk);
  endtask

  task automatic raw_bit(input logic b);
    if (!b) lvl = ~lvl;
    drive_lvl(lvl);
  endtask

  task automatic send_sync();
    lvl  = 1'b1;
    ones = 0;
    for (int i = 0; i < 7; i++) raw_bit(1'b0);
    raw_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      raw_bit(b[i]);
      if (b[i]) begin
        ones++;
        if (ones == 6) begin
          raw_bit(1'b0);
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
  endtask

  task automatic idle_j(input int n);
    lvl = 1'b1;
    for (int i = 0; i < n; i++) drive_lvl(1'b1);
  endtask

  task automatic send_eop(input string tag);
    check({tag, "_busy_pre"}, 64'(rx_busy), 64'd1);
    dp = 1'b0;
    dm = 1'b0;
    @(negedge clk);
    @(negedge clk);
    idle_j(1);
    check({tag, "_valid_lat"}, 64'(pkt_valid), 64'd1);
    check({tag, "_busy_drop"}, 64'(rx_busy), 64'd0);
    idle_j(3);
  endtask

  task automatic run_pkt(input string tag, input int n, input logic [39:0] data,
                         input logic [6:0] exp_len, input logic exp_ok);
    int v0;
    int e0;
    logic [63:0] mask;
    v0   = valid_cnt;
    e0   = err_cnt;
    mask = (64'd1 << (8 * n)) - 64'd1;
    send_sync();
    for (int i = 0; i < n; i++) send_byte(data[8*i +: 8]);
    send_eop(tag);
    check({tag, "_nvalid"}, 64'(valid_cnt - v0), 64'd1);
    check({tag, "_nerr"},   64'(err_cnt - e0),   64'd0);
    check({tag, "_len"},    64'(cap_len),        64'(exp_len));
    check({tag, "_crc_ok"}, 64'(cap_ok),         64'(exp_ok));
    check({tag, "_out"},    cap_out[63:0],       {24'd0, data} & mask);
  endtask

  initial begin
    int v0;
    int e0;
    rst_b = 1'b1;
    rx_en = 1'b1;
    dp    = 1'b1;
    dm    = 1'b0;
    lvl   = 1'b1;
    ones  = 0;
    repeat (2) @(negedge clk);
    check("rst_pkt_out", 64'(|pkt_out), 64'd0);
    check("rst_pkt_len", 64'(pkt_len), 64'd0);
    check("rst_flags", {60'd0, pkt_valid, crc_ok, rx_err, rx_busy}, 64'd0);
    rst_b = 1'b0;
    idle_j(2);

    run_pkt("ack",       1, 40'hD2,         7'd8,  1'b1);
    run_pkt("setup",     3, 40'h10002D,     7'd24, 1'b1);
    run_pkt("setup_bad", 3, 40'h18002D,     7'd24, 1'b0);
    run_pkt("data0_zl",  3, 40'h0000C3,     7'd24, 1'b1);
    run_pkt("data1_ff",  5, 40'hFFFFFFFF4B, 7'd40, 1'b1);

    // Seven decoded ones with no stuffed zero.
    v0 = valid_cnt; e0 = err_cnt;
    send_sync();
    for (int i = 0; i < 7; i++) raw_bit(1'b1);
    check("stuff_err_now", 64'(rx_err), 64'd1);
    check("stuff_busy_err", 64'(rx_busy), 64'd1);
    idle_j(1);
    check("stuff_busy_1j", 64'(rx_busy), 64'd1);
    idle_j(1);
    check("stuff_busy_2j", 64'(rx_busy), 64'd0);
    idle_j(2);
    check("stuff_nerr", 64'(err_cnt - e0), 64'd1);
    check("stuff_nvalid", 64'(valid_cnt - v0), 64'd0);

    // Line KJKJKK: SYNC breaks at its fifth decoded bit.
    v0 = valid_cnt; e0 = err_cnt;
    lvl = 1'b1;
    for (int i = 0; i < 5; i++) raw_bit(1'b0);
    raw_bit(1'b1);
    check("badsync_err_now", 64'(rx_err), 64'd1);
    idle_j(4);
    check("badsync_nerr", 64'(err_cnt - e0), 64'd1);
    check("badsync_nvalid", 64'(valid_cnt - v0), 64'd0);
    check("badsync_busy", 64'(rx_busy), 64'd0);

    // SE1 in the middle of DATA.
    v0 = valid_cnt; e0 = err_cnt;
    send_sync();
    raw_bit(1'b0); raw_bit(1'b1); raw_bit(1'b0); raw_bit(1'b0);
    dp = 1'b1; dm = 1'b1;
    @(negedge clk);
    check("se1_err_now", 64'(rx_err), 64'd1);
    idle_j(4);
    check("se1_nerr", 64'(err_cnt - e0), 64'd1);
    check("se1_nvalid", 64'(valid_cnt - v0), 64'd0);

    // Overflow: the 100th stored bit has no room.
    v0 = valid_cnt; e0 = err_cnt;
    send_sync();
    for (int i = 0; i < 99; i++) raw_bit(1'b0);
    check("ovf_no_err_99", 64'(err_cnt - e0), 64'd0);
    raw_bit(1'b0);
    check("ovf_err_now", 64'(rx_err), 64'd1);
    idle_j(4);
    check("ovf_nerr", 64'(err_cnt - e0), 64'd1);
    check("ovf_len", 64'(pkt_len), 64'd99);
    check("ovf_nvalid", 64'(valid_cnt - v0), 64'd0);

    // rx_en dropped while DATA bit 12 is on the line.
    v0 = valid_cnt; e0 = err_cnt;
    send_sync();
    send_byte(8'hC3);
    for (int i = 0; i < 4; i++) raw_bit(1'b0);
    rx_en = 1'b0;
    raw_bit(1'b0);
    check("en_busy", 64'(rx_busy), 64'd0);
    idle_j(3);
    rx_en = 1'b1;
    idle_j(2);
    check("en_len", 64'(pkt_len), 64'd12);
    check("en_out", 64'(pkt_out[11:0]), 64'h0C3);
    check("en_nstrobe", 64'((valid_cnt - v0) + (err_cnt - e0)), 64'd0);

    // Asynchronous reset during EOP, then a clean ACK.
    v0 = valid_cnt; e0 = err_cnt;
    send_sync();
    send_byte(8'hD2);
    dp = 1'b0; dm = 1'b0;
    @(negedge clk);
    #1 rst_b = 1'b1;
    #1;
    check("arst_busy", 64'(rx_busy), 64'd0);
    check("arst_len", 64'(pkt_len), 64'd0);
    check("arst_out", 64'(|pkt_out), 64'd0);
    dp = 1'b1; dm = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    idle_j(2);
    check("arst_nstrobe", 64'((valid_cnt - v0) + (err_cnt - e0)), 64'd0);
    run_pkt("ack2", 1, 40'hD2, 7'd8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/usb_dev_rx.md
Name: usb_dev_rx

Overview:
- Device-side serial receiver: the far end of the host datapath's transmit chain.
- Samples the dp/dm pair one bit per clock, finds SYNC, undoes NRZI and bit stuffing, and detects EOP.
- Assembles the packet LSB-first and checks PID and CRC5/CRC16.
- Hands the completed packet to the device protocol FSM on a single-cycle strobe.

Parameters:
PKT_W, 99, width of packet register (PID + payload + CRC); maximum accepted bit count
STUFF_RUN, 6, consecutive decoded 1s after which a stuffed 0 is mandatory

Ports:
clk  input  1  bit-rate clock; one line sample per cycle
rst_b  input  1  reset; asynchronous, active-high
rx_en  input  1  receiver enable; low forces IDLE
dp  input  1  D+ line sample
dm  input  1  D- line sample
pkt_out  output  PKT_W  received bits after SYNC; first bit in bit 0; unfilled bits 0
pkt_len  output  7  number of valid bits in pkt_out
pkt_valid  output  1  one-cycle strobe: pkt_out/pkt_len/crc_ok valid
crc_ok  output  1  PID check and CRC residual check passed; qualified by pkt_valid
rx_err  output  1  one-cycle strobe on SYNC, stuff, SE1 or overflow error
rx_busy  output  1  high from first K of SYNC until DONE/ERR exit

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; previous-level register = J; ones counter 0; CRC5 = 5'b11111; CRC16 = 16'hFFFF.
- Line decode: J = dp1/dm0; K = dp0/dm1; SE0 = 00; SE1 = 11.
- SE1 in any state except IDLE goes to ERR.
- FSM states: IDLE, SYNC, DATA, EOP, ERR.
- IDLE:
  - On K with rx_en = 1, go to SYNC and assert rx_busy.
  - Clear pkt_out, pkt_len, ones counter and both CRC registers.
- NRZI decode: bit = 1 if level equals previous level, 0 if it changed. The previous level updates every cycle in SYNC/DATA.
- SYNC:
  - The 7 cycles after the first K must decode to 0,0,0,0,0,0,1 (line KJKJKJKK total).
  - Any mismatch goes to ERR.
  - After the final 1, go to DATA.
- DATA, per cycle:
  - SE0 goes to EOP.
  - If ones counter == STUFF_RUN: decoded 0 is dropped and the counter is cleared; decoded 1 goes to ERR (stuff error).
  - Otherwise the bit is stored at pkt_out[pkt_len] and pkt_len increments.
  - The ones counter increments on 1 and clears on 0.
  - Stored bits at index >= 8 shift into both CRC5 (poly x^5+x^2+1) and CRC16 (poly 0x8005), LSB-first, serial.
  - Storing when pkt_len == PKT_W goes to ERR (overflow).
  - A stuffed 0 is counted by the ones logic but never stored.
- EOP:
  - Requires SE0 on the cycle after the first SE0, then J on the next cycle. Anything else goes to ERR.
  - On J: pulse pkt_valid, drive crc_ok, go to IDLE, drop rx_busy in the same cycle.
- crc_ok rules (PID = pkt_out[7:0]):
  - pkt_len >= 8 and PID[7:4] == ~PID[3:0] are required.
  - Token PIDs (PID[3:0] = 0001 OUT, 1001 IN, 1101 SETUP) require pkt_len == 24 and CRC5 residual 5'b01100.
  - Data PIDs (0011 DATA0, 1011 DATA1) require pkt_len >= 24, (pkt_len-8) a multiple of 8, and CRC16 residual 16'h800D.
  - Handshake PIDs (0010 ACK, 1010 NAK, 1110 STALL) require pkt_len == 8.
  - Any other PID gives crc_ok = 0.
  - A packet with crc_ok = 0 still pulses pkt_valid.
- ERR:
  - Pulse rx_err on entry, one cycle; no pkt_valid.
  - Hold until 2 consecutive J samples, then go to IDLE.
  - rx_busy stays high while in ERR and drops on exit.
- pkt_out/pkt_len hold their last values until the next SYNC start.
- rx_en deasserted in any state: next cycle IDLE, rx_busy = 0, no pkt_valid, no rx_err. pkt_out is left as-is.
- Reset mid-packet: immediate return to reset values; no strobes.
- Latency: pkt_valid is asserted in the cycle after the J that ends EOP is sampled.

Test Plan:
- ACK: SYNC + PID 0xD2 + SE0,SE0,J -> pkt_valid 1 cycle, pkt_len = 8, pkt_out[7:0] = 0xD2, crc_ok = 1, rx_err never high.
- SETUP token: bytes 2D 00 10 (addr 0, endp 0, crc5 00010) -> pkt_len = 24, crc_ok = 1. Same with crc5 field 00011 -> crc_ok = 0, pkt_valid still pulses.
- DATA0 zero-length (C3 00 00) -> pkt_len = 24, crc_ok = 1. DATA1 payload FF FF with correct CRC16 -> stuffed zeros removed, pkt_len = 40, crc_ok = 1.
- Stuff error: seven consecutive decoded 1s in DATA -> rx_err pulses once, no pkt_valid. Two J samples -> IDLE, rx_busy = 0.
- Bad SYNC (KJKJKKJ...) and SE1 mid-DATA -> each gives one rx_err pulse. Overflow: 100 unstuffed bits -> rx_err at the 100th bit.
- rx_en dropped at DATA bit 12 -> IDLE next cycle, no strobes. Async reset mid-EOP -> all outputs 0 immediately; a following clean ACK is received correctly.
